// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// UART transmitter. Accepts a byte over a start/busy handshake and serialises
// it LSB-first on tx as 8N1 (8E1 when UART_TX_PARITY_EN is defined) with each
// bit held for CLKS_PER_BIT clock cycles.
//
// Configuration macro:
//   UART_TX_PARITY_EN  inserts an even-parity bit between the data bits and
//                      the stop bit (11 bit periods per frame instead of 10).
//
// Ports:
//   clk       system clock, everything on the rising edge
//   rst       synchronous reset, active-high
//   tx_data   byte to send, sampled only on an accepted start
//   tx_start  send request, accepted only while tx_busy=0
//   tx        serial line, idle/mark level 1, driven straight from a flop
//   tx_busy   high from the cycle after acceptance through the last stop cycle
//   tx_done   one-cycle pulse in the cycle after a frame completes
// -----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q,    tx_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
`ifdef UART_TX_PARITY_EN
  // Parity is captured at acceptance because the shift register is consumed
  // by the time the parity bit goes out.
  logic             parity_q, parity_d;
`endif
  logic             bit_end;

  assign bit_end = (cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          // tx drops on the accepting edge: the start bit begins next cycle.
          state_d = START;
          shift_d = tx_data;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end

      START: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // Next bit to appear is the one about to land in shift[0].
            tx_d = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          // Still busy on this edge, so a tx_start seen now is not taken.
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before this edge.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Two instances share one clock: u_fast (CLKS_PER_BIT=4) for most traffic and
// u_slow (CLKS_PER_BIT=104) for the full-rate frame. A select bit routes the
// shared stimulus and observed outputs to one of them. The reference model is
// the frame as a list of line levels (start, data LSB-first, optional parity,
// stop); every busy cycle is compared against level[cycle / CLKS_PER_BIT].
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  bit         sel;            // 0: u_fast, 1: u_slow

  logic start_fast, start_slow;
  logic tx_fast, busy_fast, done_fast;
  logic tx_slow, busy_slow, done_slow;
  logic o_tx, o_busy, o_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign start_fast = tx_start & ~sel;
  assign start_slow = tx_start & sel;
  assign o_tx   = sel ? tx_slow   : tx_fast;
  assign o_busy = sel ? busy_slow : busy_fast;
  assign o_done = sel ? done_slow : done_fast;

  uart_tx_frame #(.CLKS_PER_BIT(4), .CNT_W(16)) u_fast (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_start (start_fast),
    .tx       (tx_fast),
    .tx_busy  (busy_fast),
    .tx_done  (done_fast)
  );

  uart_tx_frame #(.CLKS_PER_BIT(104), .CNT_W(16)) u_slow (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_start (start_slow),
    .tx       (tx_slow),
    .tx_busy  (busy_slow),
    .tx_done  (done_slow)
  );

  function automatic int cpb();
    return sel ? 104 : 4;
  endfunction

  // Line levels of one frame, one entry per bit period.
  function automatic bitq_t frame_bits(input logic [7:0] d);
    bitq_t q;
    q.push_back(1'b0);
    for (int b = 0; b < 8; b++) q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
    q.push_back(^d);
`endif
    q.push_back(1'b1);
    return q;
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, ".tx"},   o_tx,   1'b1);
    check({tag, ".busy"}, o_busy, 1'b0);
    check({tag, ".done"}, o_done, exp_done);
  endtask

  // Called at a negedge; the following posedge accepts the frame. Returns at
  // the negedge of the single idle cycle that carries tx_done.
  // junk: 0 none, 1 a 0xFF start pulse at frame cycle 12, 2 random noise.
  task automatic send_frame(input logic [7:0] d, input bit hold, input int junk);
    bitq_t bits;
    int    n;
    bits     = frame_bits(d);
    n        = bits.size() * cpb();
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = hold;
    for (int i = 0; i < n; i++) begin
      check($sformatf("tx[%0d] d=%02h", i, d), o_tx, bits[i / cpb()]);
      check($sformatf("busy[%0d]", i), o_busy, 1'b1);
      check($sformatf("done[%0d]", i), o_done, 1'b0);
      if (junk == 1 && i == 12) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
      end else if (junk == 1 && i == 13) begin
        tx_start = hold;
      end else if (junk == 2) begin
        tx_data  = 8'($urandom);
        tx_start = 1'($urandom_range(0, 1));
      end
      if (hold && i == n - 1) tx_start = 1'b1;   // present on the STOP-ending edge
      @(negedge clk);
    end
    check_idle($sformatf("end d=%02h", d), 1'b1);
  endtask

  task automatic idle_gap(input int g);
    tx_start = 1'b0;
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      check_idle("gap", 1'b0);
    end
  endtask

  // Start a frame, pulse rst after 'at' busy cycles, confirm a silent abort.
  task automatic reset_mid(input logic [7:0] d, input int at);
    bitq_t bits;
    bits     = frame_bits(d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i < at; i++) begin
      check($sformatf("pre_rst tx[%0d]", i), o_tx, bits[i / cpb()]);
      check($sformatf("pre_rst busy[%0d]", i), o_busy, 1'b1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst", 1'b0);
    @(negedge clk);
    check_idle("post_rst", 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    sel      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.fast.tx",   tx_fast,   1'b1);
    check("reset.fast.busy", busy_fast, 1'b0);
    check("reset.fast.done", done_fast, 1'b0);
    check("reset.slow.tx",   tx_slow,   1'b1);
    check("reset.slow.busy", busy_slow, 1'b0);
    check("reset.slow.done", done_slow, 1'b0);
    rst = 1'b0;
    idle_gap(2);

    // Single pulsed frame.
    send_frame(8'h55, 1'b0, 0);
    idle_gap(2);

    // tx_start held high: three frames, one idle cycle between them.
    for (int f = 0; f < 3; f++) send_frame(8'hA3, 1'b1, 0);
    idle_gap(2);

    // Mid-frame start with 0xFF is ignored.
    send_frame(8'h0F, 1'b0, 1);
    idle_gap(3);

    // Reset mid-frame, then a clean frame.
    reset_mid(8'h00, 20);
    send_frame(8'h81, 1'b0, 0);
    idle_gap(1);

    // Randomised traffic.
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      int         m;
      d = 8'($urandom);
      m = $urandom_range(0, 4);
      if (m == 4) begin
        reset_mid(d, $urandom_range(1, 39));
      end else begin
        send_frame(d, m == 1, (m == 2) ? 2 : 0);
        idle_gap($urandom_range(0, 3));
      end
    end
    idle_gap(1);

    // Full-rate instance.
    sel = 1'b1;
    idle_gap(1);
    send_frame(8'h41, 1'b0, 0);
    idle_gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
